// File: rtl/sd_data_pkg.sv
// Shared types and constants for the SD host DATA-path sequencer.
package sd_data_pkg;

    localparam int unsigned BLKLEN_W = 12;
    localparam int unsigned BLKCNT_W = 16;
    localparam int unsigned CNT_W    = 32;
    localparam int unsigned IDLE_W   = 16;

    localparam logic [1:0] MODO_HOLD = 2'b00;
    localparam logic [1:0] MODO_DOWN = 2'b01;
    localparam logic [1:0] MODO_LOAD = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_D,
        DATA,
        LOAD_C,
        CRC,
        NEXT
    } seq_state_e;

    // Counter preload for a block of len bytes: it counts len-1 down to 0.
    function automatic logic [CNT_W-1:0] blk_preload(input logic [BLKLEN_W-1:0] len);
        return CNT_W'(len - BLKLEN_W'(1));
    endfunction

endpackage

// File: rtl/data_timeout_timer.sv
// Idle-cycle watchdog between byte strobes; only present when DATA_TIMEOUT_EN is defined.
`ifdef DATA_TIMEOUT_EN
module data_timeout_timer
    import sd_data_pkg::*;
#(
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_c_o
);

    logic [IDLE_W-1:0] count_q;
    logic [IDLE_W-1:0] count_d;

    // Counts consecutive enabled cycles without a strobe; saturates at the limit.
    always_comb begin
        count_d = count_q;
        if (clear_i || !enable_i) begin
            count_d = '0;
        end else if (count_q != IDLE_W'(TIMEOUT)) begin
            count_d = count_q + IDLE_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Fires in the idle cycle that completes the allowed gap.
    assign expired_c_o = enable_i && !clear_i && (count_q == IDLE_W'(TIMEOUT - 1));

endmodule
`endif

// File: rtl/data_seq_ctrl.sv
// Multi-block DATA sequencer driving the external structural down-counter.
// Optional idle-strobe watchdog is built when DATA_TIMEOUT_EN is defined.
module data_seq_ctrl
    import sd_data_pkg::*;
#(
    parameter int unsigned CRC_LEN = 2
`ifdef DATA_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT = 1024
`endif
) (
    input  logic                iCLK,
    input  logic                iReset,
    input  logic                iStart,
    input  logic                iAbort,
    input  logic [BLKLEN_W-1:0] iBlkLen,
    input  logic [BLKCNT_W-1:0] iBlkCnt,
    input  logic                iByteValid,
    input  logic                iRCO,
    output logic                oENB,
    output logic [1:0]          oMODO,
    output logic [CNT_W-1:0]    oD,
    output logic                oInData,
    output logic                oInCrc,
    output logic [BLKCNT_W-1:0] oBlocksLeft,
    output logic                oBusy,
    output logic                oDone,
    output logic                oError
);

    seq_state_e          state_q, state_d;
    logic [BLKLEN_W-1:0] len_q, len_d;
    logic [BLKCNT_W-1:0] blocks_q, blocks_d;
    logic [CNT_W-1:0]    d_q, d_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic                busy_q, in_data_q, in_crc_q, load_q;
    logic                last_byte_c;
    logic                timeout_c;
    logic                enb_c;
    logic [1:0]          modo_c;

    assign last_byte_c = iByteValid && iRCO;

`ifdef DATA_TIMEOUT_EN
    data_timeout_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk_i       (iCLK),
        .rst_i       (iReset),
        .clear_i     (iByteValid),
        .enable_i    (in_data_q || in_crc_q),
        .expired_c_o (timeout_c)
    );
`else
    assign timeout_c = 1'b0;
`endif

    // Next-state and registered-output values.
    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        blocks_d = blocks_q;
        d_d      = d_q;
        done_d   = 1'b0;
        err_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (iStart) begin
                    if ((iBlkLen != '0) && (iBlkCnt != '0)) begin
                        len_d    = iBlkLen;
                        blocks_d = iBlkCnt;
                        d_d      = blk_preload(iBlkLen);
                        state_d  = LOAD_D;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            LOAD_D: state_d = DATA;
            DATA: begin
                if (timeout_c) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else if (last_byte_c) begin
                    d_d     = CNT_W'(CRC_LEN - 1);
                    state_d = LOAD_C;
                end
            end
            LOAD_C: state_d = CRC;
            CRC: begin
                if (timeout_c) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else if (last_byte_c) begin
                    state_d = NEXT;
                end
            end
            NEXT: begin
                blocks_d = blocks_q - BLKCNT_W'(1);
                if (blocks_q == BLKCNT_W'(1)) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    d_d     = blk_preload(len_q);
                    state_d = LOAD_D;
                end
            end
            default: state_d = IDLE;
        endcase

        // Abort overrides everything, including a same-cycle start or completion.
        if (iAbort) begin
            state_d  = IDLE;
            blocks_d = '0;
            done_d   = 1'b0;
            err_d    = 1'b0;
        end
    end

    always_ff @(posedge iCLK) begin
        if (iReset) begin
            state_q   <= IDLE;
            len_q     <= '0;
            blocks_q  <= '0;
            d_q       <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
            in_data_q <= 1'b0;
            in_crc_q  <= 1'b0;
            load_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            blocks_q  <= blocks_d;
            d_q       <= d_d;
            done_q    <= done_d;
            err_q     <= err_d;
            busy_q    <= (state_d != IDLE);
            in_data_q <= (state_d == DATA);
            in_crc_q  <= (state_d == CRC);
            load_q    <= (state_d == LOAD_D) || (state_d == LOAD_C);
        end
    end

    // Counter control: loads come from state, steps follow the strobe in the same cycle.
    always_comb begin
        enb_c  = 1'b0;
        modo_c = MODO_HOLD;
        if (!iAbort) begin
            if (load_q) begin
                enb_c  = 1'b1;
                modo_c = MODO_LOAD;
            end else if ((in_data_q || in_crc_q) && iByteValid) begin
                enb_c  = 1'b1;
                modo_c = MODO_DOWN;
            end
        end
    end

    assign oENB        = enb_c;
    assign oMODO       = modo_c;
    assign oD          = d_q;
    assign oInData     = in_data_q;
    assign oInCrc      = in_crc_q;
    assign oBlocksLeft = blocks_q;
    assign oBusy       = busy_q;
    assign oDone       = done_q;
    assign oError      = err_q;

endmodule

// File: tb/tb_data_seq_ctrl.sv
// Directed bench for data_seq_ctrl with a byte-counting reference model and an external counter model.
`timescale 1ns/1ps
module tb_data_seq_ctrl;
    import sd_data_pkg::*;

    localparam int CRCL = 2;
    localparam int TMO  = 8;
    localparam int NCYC = 170;

    logic        iCLK = 1'b0;
    logic        iReset, iStart, iAbort, iByteValid, iRCO;
    logic [11:0] iBlkLen;
    logic [15:0] iBlkCnt;
    logic        oENB, oInData, oInCrc, oBusy, oDone, oError;
    logic [1:0]  oMODO;
    logic [31:0] oD;
    logic [15:0] oBlocksLeft;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    bit chk_en = 1'b0;

    // Stimulus and expectation tables, indexed by cycle after reset.
    bit        s_start[NCYC], s_abort[NCYC], s_vld[NCYC];
    bit [11:0] s_len[NCYC];
    bit [15:0] s_cnt[NCYC];
    bit        e_enb[NCYC], e_busy[NCYC], e_done[NCYC], e_err[NCYC];
    bit        e_data[NCYC], e_crc[NCYC], e_ld[NCYC];
    bit [1:0]  e_modo[NCYC];
    bit [31:0] e_d[NCYC];
    bit [15:0] e_bl[NCYC];
    bit        r_enb[NCYC], r_ld[NCYC];
    bit [15:0] r_bl[NCYC];
    int        done_at[$];
    int        err_at[$];

    data_seq_ctrl #(
        .CRC_LEN     (CRCL)
`ifdef DATA_TIMEOUT_EN
        ,
        .TIMEOUT     (TMO)
`endif
    ) dut (
        .iCLK        (iCLK),
        .iReset      (iReset),
        .iStart      (iStart),
        .iAbort      (iAbort),
        .iBlkLen     (iBlkLen),
        .iBlkCnt     (iBlkCnt),
        .iByteValid  (iByteValid),
        .iRCO        (iRCO),
        .oENB        (oENB),
        .oMODO       (oMODO),
        .oD          (oD),
        .oInData     (oInData),
        .oInCrc      (oInCrc),
        .oBlocksLeft (oBlocksLeft),
        .oBusy       (oBusy),
        .oDone       (oDone),
        .oError      (oError)
    );

    always #5 iCLK = ~iCLK;

    // External structural counter.
    logic [31:0] cnt_q;
    always @(posedge iCLK) begin
        if (iReset) cnt_q <= '0;
        else if (oENB) begin
            if (oMODO == 2'b11) cnt_q <= oD;
            else if (oMODO == 2'b01) cnt_q <= cnt_q - 32'd1;
        end
    end
    assign iRCO = (cnt_q == 32'd0);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    // Reference model: walks a transfer by counting strobes per block and per CRC tail.
    task automatic plan(input int t0, input int len, input int cnt, input int abort_after);
        int t, n, bytes, idle;
        s_start[t0] = 1'b1;
        s_len[t0]   = 12'(len);
        s_cnt[t0]   = 16'(cnt);
        if (len == 0 || cnt == 0) begin
            e_err[t0+1] = 1'b1;
            return;
        end
        t = t0 + 1;
        for (int b = 0; b < cnt; b++) begin
            for (int ph = 0; ph < 2; ph++) begin
                n = (ph == 0) ? len : CRCL;
                e_enb[t] = 1'b1; e_modo[t] = 2'b11; e_d[t] = 32'(n - 1); e_ld[t] = 1'b1;
                e_busy[t] = 1'b1; e_bl[t] = 16'(cnt - b);
                t++;
                bytes = 0;
                idle  = 0;
                while (bytes < n) begin
                    e_busy[t] = 1'b1; e_bl[t] = 16'(cnt - b);
                    if (ph == 0) e_data[t] = 1'b1; else e_crc[t] = 1'b1;
                    if (ph == 0 && b == 0 && bytes == abort_after) begin
                        s_abort[t] = 1'b1;
                        return;
                    end
                    if (s_vld[t]) begin
                        e_enb[t] = 1'b1; e_modo[t] = 2'b01;
                        bytes++;
                        idle = 0;
                    end else begin
                        idle++;
`ifdef DATA_TIMEOUT_EN
                        if (idle == TMO) begin
                            e_err[t+1] = 1'b1;
                            return;
                        end
`endif
                    end
                    t++;
                end
            end
            e_busy[t] = 1'b1; e_bl[t] = 16'(cnt - b);
            t++;
        end
        e_done[t] = 1'b1;
    endtask

    // Per-cycle comparison against the model.
    always @(negedge iCLK) begin
        if (chk_en) begin
            chk("oENB", oENB, e_enb[cyc]);
            chk("oMODO", oMODO, e_modo[cyc]);
            chk("oBusy", oBusy, e_busy[cyc]);
            chk("oDone", oDone, e_done[cyc]);
            chk("oError", oError, e_err[cyc]);
            chk("oInData", oInData, e_data[cyc]);
            chk("oInCrc", oInCrc, e_crc[cyc]);
            chk("oBlocksLeft", oBlocksLeft, e_bl[cyc]);
            if (e_ld[cyc]) chk("oD", oD, e_d[cyc]);
            r_enb[cyc] = oENB;
            r_ld[cyc]  = oENB && (oMODO == 2'b11);
            r_bl[cyc]  = oBlocksLeft;
            if (oDone) done_at.push_back(cyc);
            if (oError) err_at.push_back(cyc);
        end
    end

    initial begin
        int n;
        // T1 single block, strobes held high
        for (int c = 2; c < 16; c++) s_vld[c] = 1'b1;
        plan(2, 4, 1, -1);
        // T2 three blocks of two bytes
        for (int c = 20; c < 46; c++) s_vld[c] = 1'b1;
        plan(20, 2, 3, -1);
        // T3 strobe every third cycle
        for (int c = 50; c < 76; c++) if ((c - 50) % 3 == 0) s_vld[c] = 1'b1;
        plan(50, 3, 1, -1);
        // T4 rejected starts
        plan(80, 0, 1, -1);
        plan(84, 5, 0, -1);
        // T5 abort after 2 of 8 bytes, then T6 normal restart
        for (int c = 90; c < 97; c++) s_vld[c] = 1'b1;
        plan(90, 8, 1, 2);
        for (int c = 100; c < 119; c++) s_vld[c] = 1'b1;
        plan(100, 2, 2, -1);
        // T7 start and abort together in IDLE
        s_start[120] = 1'b1; s_abort[120] = 1'b1; s_len[120] = 12'd3; s_cnt[120] = 16'd1;
`ifdef DATA_TIMEOUT_EN
        // T8 strobes stop inside DATA
        plan(130, 4, 1, -1);
`endif

        iReset = 1'b1; iStart = 1'b0; iAbort = 1'b0; iByteValid = 1'b0;
        iBlkLen = '0; iBlkCnt = '0;
        repeat (3) @(posedge iCLK);
        @(negedge iCLK);
        chk("rst_oENB", oENB, 0);
        chk("rst_oMODO", oMODO, 0);
        chk("rst_oD", oD, 0);
        chk("rst_oInData", oInData, 0);
        chk("rst_oInCrc", oInCrc, 0);
        chk("rst_oBlocksLeft", oBlocksLeft, 0);
        chk("rst_oBusy", oBusy, 0);
        chk("rst_oDone", oDone, 0);
        chk("rst_oError", oError, 0);
        @(posedge iCLK);
        #1 iReset = 1'b0;

        for (int c = 0; c < NCYC - 1; c++) begin
            @(posedge iCLK);
            #1;
            cyc        = c;
            chk_en     = 1'b1;
            iStart     = s_start[c];
            iAbort     = s_abort[c];
            iByteValid = s_vld[c];
            iBlkLen    = s_len[c];
            iBlkCnt    = s_cnt[c];
        end
        @(posedge iCLK);
        #1 chk_en = 1'b0;

        // Hand-computed pins on the model and DUT
        chk("done_count", 32'(done_at.size()), 4);
        if (done_at.size() == 4) begin
            chk("done_single", 32'(done_at[0]), 12);
            chk("done_multi", 32'(done_at[1]), 42);
            chk("done_gapped", 32'(done_at[2]), 67);
            chk("done_restart", 32'(done_at[3]), 115);
        end
`ifdef DATA_TIMEOUT_EN
        chk("err_count", 32'(err_at.size()), 3);
        if (err_at.size() == 3) chk("err_timeout", 32'(err_at[2]), 140);
`else
        chk("err_count", 32'(err_at.size()), 2);
`endif
        if (err_at.size() >= 2) begin
            chk("err_len0", 32'(err_at[0]), 81);
            chk("err_cnt0", 32'(err_at[1]), 85);
        end
        n = 0;
        for (int c = 20; c <= 42; c++) if (r_ld[c]) n++;
        chk("multi_loads", 32'(n), 6);
        chk("bl_blk1", 32'(r_bl[21]), 3);
        chk("bl_blk2", 32'(r_bl[28]), 2);
        chk("bl_blk3", 32'(r_bl[35]), 1);
        chk("bl_end", 32'(r_bl[42]), 0);
        n = 0;
        for (int c = 50; c <= 67; c++) if (r_enb[c]) n++;
        chk("gapped_enb_cycles", 32'(n), 7);
        chk("gapped_enb_idle", 32'(r_enb[54]), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
